// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions for the ALU and its divide/remainder companion.
// Holds the RV32M divide op encoding, the divider FSM state encoding and the
// default operand width.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Encoding of the 2-bit op field presented to the divider.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
// Ports:
//   i_rem     - partial remainder before this step (always < i_divisor)
//   i_bit     - next dividend bit shifted into the remainder
//   i_divisor - divisor magnitude
//   o_rem     - partial remainder after the trial subtract
//   o_qbit    - quotient bit produced by this step
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_trial;

  // The shifted remainder keeps its top bit: with an unsigned divisor above
  // 2^(XLEN-1) the remainder can legitimately use all XLEN bits before the shift.
  assign w_shifted = {i_rem, i_bit};
  assign w_trial   = w_shifted - {1'b0, i_divisor};

  // Both operands of the trial subtract are below 2^XLEN unless the shifted
  // value has its top bit set, so the sign of the (XLEN+1)-bit difference is
  // the borrow; a set top bit on the shifted value always means "fits".
  assign o_qbit = w_shifted[XLEN] | ~w_trial[XLEN];
  assign o_rem  = o_qbit ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];

endmodule

// File: rtl/alu_divider.sv
// Sequential RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle; a normal request
// completes XLEN+1 cycles after acceptance, divide-by-zero and signed overflow
// complete after one cycle.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset, aborts any operation in flight
//   start    - request strobe, sampled only while busy is low
//   op       - DIV=0, DIVU=1, REM=2, REMU=3
//   dividend - rs1 operand
//   divisor  - rs2 operand
//   busy     - high from the acceptance edge until the edge that raises done
//   done     - one-cycle completion pulse
//   result   - quotient or remainder, held until the next completion
module alu_divider
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_BIT = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ONE      = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      r_state;
  div_state_e      w_next_state;
  div_op_e         w_op;

  logic [XLEN-1:0] r_work;     // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0] r_rem;      // partial remainder
  logic [XLEN-1:0] r_divisor;  // divisor magnitude
  logic [CW-1:0]   r_count;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_signed_op;
  logic            w_x_neg;
  logic            w_y_neg;
  logic [XLEN-1:0] w_x_abs;
  logic [XLEN-1:0] w_y_abs;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_step_rem;
  logic            w_step_q;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  // ---------------------------------------------------------------------------
  // Operand preparation, evaluated at the acceptance edge
  // ---------------------------------------------------------------------------
  assign w_op        = div_op_e'(op);
  assign w_signed_op = (w_op == DIV_OP_DIV) || (w_op == DIV_OP_REM);
  assign w_x_neg     = w_signed_op & dividend[XLEN-1];
  assign w_y_neg     = w_signed_op & divisor[XLEN-1];
  assign w_x_abs     = w_x_neg ? (~dividend + ONE) : dividend;
  assign w_y_abs     = w_y_neg ? (~divisor + ONE) : divisor;
  assign w_div0      = (divisor == '0);
  assign w_ovf       = w_signed_op && (dividend == MIN_NEG) && (divisor == '1);

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_bit    (r_work[XLEN-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_step_rem),
    .o_qbit   (w_step_q)
  );

  // Sign fixup; special cases load neutral sign flags so they pass through.
  assign w_q_fix = r_neg_q ? (~r_work + ONE) : r_work;
  assign w_r_fix = r_neg_r ? (~r_rem + ONE) : r_rem;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: the default assignment first guarantees no path leaves the
    // signal unassigned, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = (w_div0 || w_ovf) ? ST_FINISH : ST_DIVIDE;
      ST_DIVIDE: if (r_count == '0) w_next_state = ST_FINISH;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: every register, result included, is cleared on reset so an aborted
  // divide leaves nothing visible and no stale flags for the next request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_rem <= (w_op == DIV_OP_REM) || (w_op == DIV_OP_REMU);
            r_count  <= LAST_BIT;
            if (w_div0) begin
              // Quotient all ones, remainder is the raw dividend.
              r_work  <= '1;
              r_rem   <= dividend;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_ovf) begin
              // Quotient is the most negative value, remainder zero.
              r_work  <= dividend;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_work    <= w_x_abs;
              r_rem     <= '0;
              r_divisor <= w_y_abs;
              r_neg_q   <= w_x_neg ^ w_y_neg;
              r_neg_r   <= w_x_neg;
            end
          end
        end
        ST_DIVIDE: begin
          r_rem   <= w_step_rem;
          r_work  <= {r_work[XLEN-2:0], w_step_q};
          r_count <= r_count - CNT_ONE;
        end
        ST_FINISH: begin
          r_result <= r_is_rem ? w_r_fix : w_q_fix;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed cases, handshake corner cases,
// mid-operation reset and a randomized sweep against a behavioural model built
// on the language's own / and % operators plus the RISC-V special-case rules.
module tb_alu_divider;
  import cpu_pkg::*;

  localparam int              W       = 32;
  localparam logic [W-1:0]    MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  alu_divider #(.XLEN(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic with the RISC-V divide rules.
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    logic signed [W-1:0] sx;
    logic signed [W-1:0] sy;
    logic                is_signed;
    sx = x;
    sy = y;
    is_signed = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
    if (y == '0) return ((o == DIV_OP_DIV) || (o == DIV_OP_DIVU)) ? '1 : x;
    if (is_signed && x == MIN_NEG && y == '1) return (o == DIV_OP_DIV) ? MIN_NEG : '0;
    case (o)
      DIV_OP_DIV:  return sx / sy;
      DIV_OP_DIVU: return x / y;
      DIV_OP_REM:  return sx % sy;
      default:     return x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
    logic is_signed;
    is_signed = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
    if (y == '0 || (is_signed && x == MIN_NEG && y == '1)) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return MIN_NEG;
      4:       return W'($urandom_range(0, 15));
      5:       return '1 - W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Drive a request for one edge; the caller guarantees busy is low.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_res, input int lat, input string name);
    exp_t e;
    op       = o;
    dividend = x;
    divisor  = y;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = W'($urandom);
    divisor  = W'($urandom);
    e.res  = exp_res;
    e.lat  = lat;
    e.acc  = cyc;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_completed"}, W'(sb.size()), '0);
    if (sb.size() != 0) sb.delete();
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=done with result %h required=no done pulse", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        check({mon_e.name, "_latency"}, W'(cyc - mon_e.acc), W'(mon_e.lat));
      end
    end
  end

  initial begin
    int n;
    int seen;
    logic [1:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    // Reset state
    #12;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);
    #8 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned and signed basics
    issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    check("busy_after_accept", W'(busy), 32'd1);
    drain("divu_100_7");
    issue(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    drain("remu_100_7");
    issue(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, "div_m100_7");
    drain("div_m100_7");
    issue(DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, "rem_m100_7");
    drain("rem_m100_7");

    // Divide by zero and signed overflow take the one-cycle path
    issue(DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
    drain("div_by_zero");
    issue(DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero");
    drain("remu_by_zero");
    issue(DIV_OP_DIV, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1, "div_overflow");
    drain("div_overflow");
    issue(DIV_OP_REM, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 1, "rem_overflow");
    drain("rem_overflow");

    // Large unsigned divisor exercises the full-width partial remainder
    issue(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, "remu_big_divisor");
    drain("remu_big_divisor");

    // start while busy must be ignored
    issue(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, "ignored_start");
    repeat (5) @(posedge clk);
    #1;
    op       = DIV_OP_DIVU;
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("ignored_start");

    // start in the done cycle is accepted back-to-back
    issue(DIV_OP_DIV, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 33, "b2b_first");
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_done_seen", W'(done), 32'd1);
    check("b2b_busy_in_done", W'(busy), '0);
    issue(DIV_OP_REMU, 32'd1000, 32'd7, 32'd6, 33, "b2b_second");
    drain("b2b_second");

    // Reset in the middle of a divide aborts it without a done pulse
    issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, "aborted");
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_result", result, '0);
    sb.delete();
    #10 reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", W'(seen), '0);
    @(posedge clk);
    #1;
    issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, "after_reset");
    drain("after_reset");

    // Randomized sweep across all ops
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom);
      rx = pick_operand();
      ry = pick_operand();
      issue(ro, rx, ry, ref_result(ro, rx, ry), ref_latency(ro, rx, ry),
            $sformatf("rand%0d_op%0d_%h_%h", i, ro, rx, ry));
      drain("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
